// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-request / pipeline-control bundle between the hazard sources and the stall sequencer.
// master = hazard/pipeline side (drives requests), slave = stall sequencer (drives controls).
interface pipeline_stall_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              LoadUse;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchTarget;
  logic              ICacheStall;
  logic              DCacheStall;

  logic              PCWrite;
  logic              PCSel;
  logic [ADDR_W-1:0] RedirectPC;
  logic              IFID_Write;
  logic              IFID_Flush;
  logic              IDEX_Write;
  logic              IDEX_Flush;
  logic              EXMEM_Write;
  logic              MEMWB_Write;
  logic [CNT_W-1:0]  StallCount;
  logic              Timeout;

  modport master (
    output LoadUse, BranchTaken, BranchTarget, ICacheStall, DCacheStall,
    input  PCWrite, PCSel, RedirectPC, IFID_Write, IFID_Flush, IDEX_Write,
           IDEX_Flush, EXMEM_Write, MEMWB_Write, StallCount, Timeout
  );

  modport slave (
    input  LoadUse, BranchTaken, BranchTarget, ICacheStall, DCacheStall,
    output PCWrite, PCSel, RedirectPC, IFID_Write, IFID_Flush, IDEX_Write,
           IDEX_Flush, EXMEM_Write, MEMWB_Write, StallCount, Timeout
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage write enables, bubbles,
// PC redirect (with deferral while fetch is busy), stall counter and D-side watchdog.
module pipeline_stall_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stall_ctrl_if.slave  bus
);

  localparam int DW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0]    DW_MAX  = DW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, REDIR_WAIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pend_tgt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [DW-1:0]     dwait_cnt;
  logic              timeout_q;

  logic              pc_write;
  logic              pc_sel;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ifid_write, ifid_flush;
  logic              idex_write, idex_flush;
  logic              exmem_write, memwb_write;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (!bus.DCacheStall && bus.BranchTaken && bus.ICacheStall)
          state_nxt = REDIR_WAIT;
      end
      REDIR_WAIT: begin
        if (!bus.DCacheStall && !bus.ICacheStall)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Output logic: Write defaults to 1, Flush to 0; Flush overrides Write downstream
  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = 1'b0;
    redirect_pc = '0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          redirect_pc = bus.BranchTarget;
          if (bus.DCacheStall) begin
            // Whole pipe frozen; the EX branch stays put and is replayed on release
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
          end else if (bus.BranchTaken && !bus.ICacheStall) begin
            pc_sel     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (bus.BranchTaken) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (bus.LoadUse) begin
            // Covers load-use alone and load-use with a fetch stall: same response
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (bus.ICacheStall) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        REDIR_WAIT: begin
          redirect_pc = pend_tgt;
          ifid_flush  = 1'b1;
          if (bus.DCacheStall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
          end else if (bus.ICacheStall) begin
            pc_write = 1'b0;
          end else begin
            pc_sel = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Deferred redirect target; a late branch in REDIR_WAIT replaces the older one
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_tgt <= '0;
    end else if (state == RUN) begin
      if (!bus.DCacheStall && bus.BranchTaken && bus.ICacheStall)
        pend_tgt <= bus.BranchTarget;
    end else if (bus.BranchTaken) begin
      pend_tgt <= bus.BranchTarget;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (!pc_write && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Watchdog: Timeout latches on the edge that completes the TIMEOUT-th stalled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dwait_cnt <= '0;
      timeout_q <= 1'b0;
    end else if (bus.DCacheStall) begin
      if (dwait_cnt != DW_MAX) begin
        dwait_cnt <= dwait_cnt + 1'b1;
        if (dwait_cnt + 1'b1 == DW_MAX)
          timeout_q <= 1'b1;
      end
    end else begin
      dwait_cnt <= '0;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.PCSel       = pc_sel;
  assign bus.RedirectPC  = redirect_pc;
  assign bus.IFID_Write  = ifid_write;
  assign bus.IFID_Flush  = ifid_flush;
  assign bus.IDEX_Write  = idex_write;
  assign bus.IDEX_Flush  = idex_flush;
  assign bus.EXMEM_Write = exmem_write;
  assign bus.MEMWB_Write = memwb_write;
  assign bus.StallCount  = stall_cnt;
  assign bus.Timeout     = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (CNT_W=3, TIMEOUT=4 to reach saturation/watchdog quickly).
module tb_pipeline_stall_ctrl;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;

  // ctl = {PCWrite, PCSel, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Write}
  localparam logic [7:0] C_NORM  = 8'hAB;
  localparam logic [7:0] C_LU    = 8'h0F;
  localparam logic [7:0] C_BR    = 8'hFF;
  localparam logic [7:0] C_BR_IC = 8'h3F;
  localparam logic [7:0] C_IC    = 8'h3B;
  localparam logic [7:0] C_RDGO  = 8'hFB;
  localparam logic [7:0] C_DC    = 8'h00;
  localparam logic [7:0] C_RDDC  = 8'h10;
  localparam logic [7:0] C_RST   = 8'h14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  pipeline_stall_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ctl;
  assign ctl = {bus.PCWrite, bus.PCSel, bus.IFID_Write, bus.IFID_Flush,
                bus.IDEX_Write, bus.IDEX_Flush, bus.EXMEM_Write, bus.MEMWB_Write};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs just after the falling edge; outputs are sampled 1ns later
  task automatic step(input logic lu, input logic bt, input logic [ADDR_W-1:0] tgt,
                      input logic ic, input logic dc);
    @(negedge clk);
    bus.LoadUse      = lu;
    bus.BranchTaken  = bt;
    bus.BranchTarget = tgt;
    bus.ICacheStall  = ic;
    bus.DCacheStall  = dc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.LoadUse = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
    bus.ICacheStall = 1'b0; bus.DCacheStall = 1'b0;
    #1;
    chk("rst_ctl", ctl, C_RST);
    chk("rst_redir", bus.RedirectPC, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    bus.LoadUse = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
    bus.ICacheStall = 1'b0; bus.DCacheStall = 1'b0;

    // Reset state then idle
    do_reset();
    chk("idle_ctl", ctl, C_NORM);
    chk("idle_cnt", bus.StallCount, 0);
    chk("idle_tmo", bus.Timeout, 0);

    // Single load-use bubble
    step(1, 0, 0, 0, 0);
    chk("lu_ctl", ctl, C_LU);
    step(0, 0, 0, 0, 0);
    chk("lu_after_ctl", ctl, C_NORM);
    chk("lu_cnt", bus.StallCount, 1);

    // Taken branch, fetch ready
    do_reset();
    step(0, 1, 32'h100, 0, 0);
    chk("br_ctl", ctl, C_BR);
    chk("br_pc", bus.RedirectPC, 32'h100);
    step(0, 0, 0, 0, 0);
    chk("br_after_ctl", ctl, C_NORM);
    chk("br_cnt", bus.StallCount, 0);

    // Taken branch deferred behind 3 fetch-stall cycles
    do_reset();
    step(0, 1, 32'h200, 1, 0);
    chk("dfr_c1_ctl", ctl, C_BR_IC);
    step(0, 0, 0, 1, 0);
    chk("dfr_c2_ctl", ctl, C_IC);
    chk("dfr_c2_pc", bus.RedirectPC, 32'h200);
    step(1, 0, 0, 1, 0);
    chk("dfr_c3_ctl", ctl, C_IC);
    step(0, 0, 0, 0, 0);
    chk("dfr_go_ctl", ctl, C_RDGO);
    chk("dfr_go_pc", bus.RedirectPC, 32'h200);
    step(0, 0, 0, 0, 0);
    chk("dfr_run_ctl", ctl, C_NORM);
    chk("dfr_cnt", bus.StallCount, 3);

    // D-side stall freezes everything, branch replays on release
    do_reset();
    step(1, 1, 32'h300, 0, 1);
    chk("dc_c1_ctl", ctl, C_DC);
    step(1, 1, 32'h300, 1, 1);
    chk("dc_c2_ctl", ctl, C_DC);
    step(0, 1, 32'h300, 0, 0);
    chk("dc_rel_ctl", ctl, C_BR);
    chk("dc_rel_pc", bus.RedirectPC, 32'h300);
    step(0, 0, 0, 0, 0);
    chk("dc_after_ctl", ctl, C_NORM);
    chk("dc_cnt", bus.StallCount, 2);

    // D-side stall while a redirect is pending
    do_reset();
    step(0, 1, 32'h40, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("rddc_ctl", ctl, C_RDDC);
    step(0, 0, 0, 0, 0);
    chk("rddc_go_ctl", ctl, C_RDGO);
    chk("rddc_go_pc", bus.RedirectPC, 32'h40);

    // Newest target wins inside REDIR_WAIT
    do_reset();
    step(0, 1, 32'h500, 1, 0);
    step(0, 1, 32'h600, 1, 0);
    chk("nw_wait_ctl", ctl, C_IC);
    step(0, 0, 0, 0, 0);
    chk("nw_go_ctl", ctl, C_RDGO);
    chk("nw_go_pc", bus.RedirectPC, 32'h600);

    // Reset inside REDIR_WAIT drops the pending redirect
    do_reset();
    step(0, 1, 32'h80, 1, 0);
    do_reset();
    chk("rstw_ctl", ctl, C_NORM);
    step(0, 0, 0, 0, 0);
    chk("rstw_ctl2", ctl, C_NORM);

    // Fetch stall combos
    step(1, 0, 0, 1, 0);
    chk("iclu_ctl", ctl, C_LU);
    step(0, 0, 0, 1, 0);
    chk("ic_ctl", ctl, C_IC);

    // Watchdog: Timeout visible from the 5th stalled cycle, sticky until reset
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 0, 1);
      chk($sformatf("tmo_c%0d", k), bus.Timeout, (k >= 5) ? 1 : 0);
    end
    step(0, 0, 0, 0, 0);
    chk("tmo_sticky", bus.Timeout, 1);
    chk("tmo_cnt", bus.StallCount, 5);
    do_reset();
    chk("tmo_clr", bus.Timeout, 0);

    // A gap in the D-side stall restarts the watchdog run
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("gap_no_tmo", bus.Timeout, 0);
    step(0, 0, 0, 0, 0);
    chk("gap_tmo", bus.Timeout, 1);

    // StallCount saturates at 7
    do_reset();
    for (int k = 0; k < 10; k++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("sat_cnt", bus.StallCount, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Combines these hazard requests into per-stage register write-enables, flushes and PC redirect control:
  - load-use stall from hazard detection;
  - taken branch resolved in EX;
  - instruction-memory wait;
  - data-memory wait.
- Holds a deferred branch redirect when the fetch port is busy.
- Keeps a saturating stall-cycle counter and a data-memory watchdog.

Parameters:
ADDR_W, 32, PC / branch target width
CNT_W, 16, stall counter width
TIMEOUT, 64, consecutive DCacheStall cycles that raise Timeout (must be ≥1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
LoadUse  input  1  load-use hazard from the hazard detection unit (ID stage)
BranchTaken  input  1  branch/jump in EX is taken
BranchTarget  input  ADDR_W  target address of the EX branch
ICacheStall  input  1  instruction fetch not ready this cycle
DCacheStall  input  1  data access in MEM not complete this cycle
PCWrite  output  1  PC register update enable
PCSel  output  1  1 = PC loads RedirectPC, 0 = sequential PC
RedirectPC  output  ADDR_W  redirect address
IFID_Write  output  1  IF/ID register write enable
IFID_Flush  output  1  IF/ID loads a bubble (NOP)
IDEX_Write  output  1  ID/EX register write enable
IDEX_Flush  output  1  ID/EX loads a bubble (control fields zeroed)
EXMEM_Write  output  1  EX/MEM write enable
MEMWB_Write  output  1  MEM/WB write enable
StallCount  output  CNT_W  saturating count of cycles with PCWrite=0
Timeout  output  1  sticky: DCacheStall held ≥ TIMEOUT consecutive cycles

Behaviour:
- Control outputs are combinational from state and inputs. Counters, pending target and FSM are registered.
- While rst=1:
  - all *_Write = 0; IFID_Flush = IDEX_Flush = 1; PCSel = 0; RedirectPC = 0.
  - Next state RUN; pending target cleared; StallCount = 0; Timeout = 0; DWaitCnt = 0.
- Flush wins over Write: when Flush=1, the register loads a bubble regardless of Write. Defaults are all Write=1, Flush=0, PCSel=0.
- FSM states: RUN, REDIR_WAIT.
- RUN, priority highest first:
  1. DCacheStall=1:
     - all five Write = 0, no flush; pipeline frozen.
     - BranchTaken is ignored; it stays asserted because EX is frozen.
  2. BranchTaken=1 and ICacheStall=0:
     - PCWrite=1, PCSel=1, RedirectPC=BranchTarget.
     - IFID_Flush=1, IDEX_Flush=1.
  3. BranchTaken=1 and ICacheStall=1:
     - PCWrite=0, IFID_Flush=1, IDEX_Flush=1.
     - Latch BranchTarget into PendTgt; next state REDIR_WAIT.
  4. ICacheStall=1 and LoadUse=1: PCWrite=0, IFID_Write=0, IDEX_Flush=1.
  5. ICacheStall=1 only: PCWrite=0, IFID_Flush=1; back end advances.
  6. LoadUse=1 only: PCWrite=0, IFID_Write=0, IDEX_Flush=1.
- REDIR_WAIT:
  - RedirectPC = PendTgt; IFID_Flush=1 every cycle, so the stale fetch is discarded. LoadUse is ignored.
  - DCacheStall=1: all Write=0; IFID_Flush stays 1; remain in state.
  - ICacheStall=1: PCWrite=0; remain in state.
  - ICacheStall=0: PCWrite=1, PCSel=1; next state RUN.
  - BranchTaken=1 here (must not occur; EX holds a bubble): overwrite PendTgt with BranchTarget. The newest target wins.
- StallCount:
  - Increments each non-reset cycle with PCWrite=0.
  - Saturates at 2^CNT_W−1; no wrap.
- DWaitCnt (internal):
  - Increments while DCacheStall=1; clears when DCacheStall=0. Saturates at TIMEOUT.
  - Timeout sets on the edge where the incremented value reaches TIMEOUT, so it is visible the cycle after the TIMEOUT-th stalled cycle.
  - Timeout clears only on rst.
- Reset mid-REDIR_WAIT discards PendTgt; no redirect is issued after reset.

Test Plan:
- Reset, then all inputs 0 → PCWrite=IFID_Write=IDEX_Write=EXMEM_Write=MEMWB_Write=1, flushes 0, StallCount=0.
- LoadUse=1 for 1 cycle → that cycle PCWrite=0, IFID_Write=0, IDEX_Flush=1; next cycle normal; StallCount=1.
- BranchTaken=1, BranchTarget=0x0000_0100, ICacheStall=0 → PCSel=1, RedirectPC=0x100, IFID_Flush=IDEX_Flush=1, PCWrite=1; state stays RUN.
- BranchTaken=1, target 0x200, ICacheStall=1 for 3 cycles → 3 cycles PCWrite=0 with IFID_Flush=1. On the cycle ICacheStall drops: PCWrite=1, PCSel=1, RedirectPC=0x200, then back to RUN. StallCount=3.
- DCacheStall=1 together with BranchTaken=1 and LoadUse=1 → all Write=0, no flush, PCSel=0. On release, the branch redirect occurs.
- TIMEOUT=4, DCacheStall held 5 cycles → Timeout=1 from cycle 5 onward, remaining 1 after DCacheStall drops; rst clears it. StallCount saturation checked with CNT_W=3: 10 stalled cycles → StallCount=7.
